// File: rtl/bus_dma_pkg.sv
// bus_dma_pkg -- shared types and constants for the bus_dma block.
//
// The bus macros (BUS_WIDTH, BUS_ACC_WIDTH, BUS_ACC_1B/2B/4B) are normally
// supplied by femto.vh. Matching defaults are provided here so the block
// still elaborates when that header is not part of the build. The rest of
// the block uses the package constants below rather than the macros, so
// it does not depend on the order in which files are compiled.
//
// Contents:
//   BUS_W, ACC_W              bus data width, access-size field width
//   ACC_1B, ACC_2B, ACC_4B    access-size encodings
//   state_t                   transfer FSM states
//   byte_mask()               mask keeping the low n bytes of a bus word
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

package bus_dma_pkg;

  localparam int BUS_W = `BUS_WIDTH;
  localparam int ACC_W = `BUS_ACC_WIDTH;

  localparam logic [ACC_W-1:0] ACC_1B = `BUS_ACC_1B;
  localparam logic [ACC_W-1:0] ACC_2B = `BUS_ACC_2B;
  localparam logic [ACC_W-1:0] ACC_4B = `BUS_ACC_4B;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REQ = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  // Keeps the low n bytes of a bus word and zeroes the rest, so that
  // write data never carries stale bytes above the access size.
  function automatic logic [BUS_W-1:0] byte_mask(input logic [2:0] n);
    logic [BUS_W-1:0] m;
    m = '0;
    for (int i = 0; i < BUS_W / 8; i++) begin
      if (i < int'(n)) m[i*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/bus_dma_sizer.sv
// bus_dma_sizer -- combinational access-size selector.
//
// Picks the widest access that both addresses are aligned for and that
// does not run past the end of the transfer.
//
// Ports:
//   src_lo     in   2          low bits of the current source address
//   dst_lo     in   2          low bits of the current destination address
//   remaining  in   LEN_WIDTH  bytes still to copy (non-zero when used)
//   acc        out  ACC_W      selected access size
//   n          out  3          byte count for that size (1, 2 or 4)
module bus_dma_sizer
  import bus_dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic [1:0]           src_lo,
  input  logic [1:0]           dst_lo,
  input  logic [LEN_WIDTH-1:0] remaining,
  output logic [ACC_W-1:0]     acc,
  output logic [2:0]           n
);

  always_comb begin
    acc = ACC_1B;
    n   = 3'd1;
    if (src_lo == 2'b00 && dst_lo == 2'b00 && remaining >= LEN_WIDTH'(3'd4)) begin
      acc = ACC_4B;
      n   = 3'd4;
    end else if (!src_lo[0] && !dst_lo[0] && remaining >= LEN_WIDTH'(3'd2)) begin
      acc = ACC_2B;
      n   = 3'd2;
    end
  end

endmodule

// File: rtl/bus_dma.sv
// bus_dma -- single-channel memory-to-memory copy engine.
//
// Each beat is a read followed by the paired write of the same size. The
// bus is a simple request/response bus: req pulses for one cycle with
// addr/w_rb/acc/wdata valid, the responder answers with resp one or more
// cycles later, or rejects the request with fault in the req cycle.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   start            one-cycle pulse, latches src/dst/len when idle
//   src, dst, len    source, destination byte addresses and byte count
//   busy             transfer in progress
//   done, err        one-cycle completion / failure pulses
//   err_addr         address of the failing access, held until next start
//   addr, w_rb, acc, wdata, req   bus request side
//   rdata, resp, fault            bus response side
module bus_dma
  import bus_dma_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter int          LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [31:0]          src,
  input  logic [31:0]          dst,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          err_addr,
  output logic [31:0]          addr,
  output logic                 w_rb,
  output logic [ACC_W-1:0]     acc,
  output logic [BUS_W-1:0]     wdata,
  output logic                 req,
  input  logic [BUS_W-1:0]     rdata,
  input  logic                 resp,
  input  logic                 fault
);

  state_t               state_reg, state_next;
  logic [31:0]          src_reg, src_next;
  logic [31:0]          dst_reg, dst_next;
  logic [LEN_WIDTH-1:0] rem_reg, rem_next;
  logic [ACC_W-1:0]     acc_reg, acc_next;
  logic [2:0]           n_reg, n_next;
  logic [BUS_W-1:0]     data_reg, data_next;
  logic [31:0]          cnt_reg, cnt_next;
  logic [31:0]          err_addr_reg, err_addr_next;
  logic                 fin_err_reg, fin_err_next;
  logic                 done_reg, done_next;
  logic                 err_reg, err_next;

  logic [ACC_W-1:0]     sz_acc;
  logic [2:0]           sz_n;
  logic [LEN_WIDTH-1:0] rem_dec;
  logic                 timeout_hit;

  bus_dma_sizer #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_sizer (
    .src_lo    (src_reg[1:0]),
    .dst_lo    (dst_reg[1:0]),
    .remaining (rem_reg),
    .acc       (sz_acc),
    .n         (sz_n)
  );

  assign rem_dec = rem_reg - LEN_WIDTH'(n_reg);

  // cnt_reg holds the number of cycles since the req edge. The error pulse
  // lands two cycles after the timeout decision (one in FINISH, one for the
  // registered pulse), so deciding at TIMEOUT-2 puts err exactly TIMEOUT
  // cycles after the request.
  assign timeout_hit = (cnt_reg + 32'd2) >= TIMEOUT;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= ST_IDLE;
      src_reg      <= '0;
      dst_reg      <= '0;
      rem_reg      <= '0;
      acc_reg      <= ACC_1B;
      n_reg        <= 3'd1;
      data_reg     <= '0;
      cnt_reg      <= '0;
      err_addr_reg <= '0;
      fin_err_reg  <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      src_reg      <= src_next;
      dst_reg      <= dst_next;
      rem_reg      <= rem_next;
      acc_reg      <= acc_next;
      n_reg        <= n_next;
      data_reg     <= data_next;
      cnt_reg      <= cnt_next;
      err_addr_reg <= err_addr_next;
      fin_err_reg  <= fin_err_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    src_next      = src_reg;
    dst_next      = dst_reg;
    rem_next      = rem_reg;
    acc_next      = acc_reg;
    n_next        = n_reg;
    data_next     = data_reg;
    cnt_next      = cnt_reg;
    err_addr_next = err_addr_reg;
    fin_err_next  = fin_err_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          src_next      = src;
          dst_next      = dst;
          rem_next      = len;
          err_addr_next = '0;
          fin_err_next  = 1'b0;
          state_next    = (len != '0) ? ST_RD_REQ : ST_FINISH;
        end
      end

      ST_RD_REQ: begin
        // The size chosen here is kept for the paired write.
        acc_next = sz_acc;
        n_next   = sz_n;
        cnt_next = 32'd1;
        if (fault) begin
          fin_err_next  = 1'b1;
          err_addr_next = src_reg;
          state_next    = ST_FINISH;
        end else begin
          state_next = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        cnt_next = cnt_reg + 32'd1;
        if (resp) begin
          data_next  = rdata & byte_mask(n_reg);
          state_next = ST_WR_REQ;
        end else if (timeout_hit) begin
          fin_err_next  = 1'b1;
          err_addr_next = src_reg;
          state_next    = ST_FINISH;
        end
      end

      ST_WR_REQ: begin
        cnt_next = 32'd1;
        if (fault) begin
          fin_err_next  = 1'b1;
          err_addr_next = dst_reg;
          state_next    = ST_FINISH;
        end else begin
          state_next = ST_WR_WAIT;
        end
      end

      ST_WR_WAIT: begin
        cnt_next = cnt_reg + 32'd1;
        if (resp) begin
          src_next   = src_reg + 32'(n_reg);
          dst_next   = dst_reg + 32'(n_reg);
          rem_next   = rem_dec;
          state_next = (rem_dec != '0) ? ST_RD_REQ : ST_FINISH;
        end else if (timeout_hit) begin
          fin_err_next  = 1'b1;
          err_addr_next = dst_reg;
          state_next    = ST_FINISH;
        end
      end

      ST_FINISH: begin
        done_next  = !fin_err_reg;
        err_next   = fin_err_reg;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // Bus outputs decode directly from state so that they are quiet (and at
  // their reset values) whenever no access is in flight.
  assign req   = (state_reg == ST_RD_REQ) || (state_reg == ST_WR_REQ);
  assign w_rb  = (state_reg == ST_WR_REQ) || (state_reg == ST_WR_WAIT);
  assign addr  = ((state_reg == ST_RD_REQ) || (state_reg == ST_RD_WAIT)) ? src_reg :
                 ((state_reg == ST_WR_REQ) || (state_reg == ST_WR_WAIT)) ? dst_reg : 32'd0;
  assign acc   = (state_reg == ST_RD_REQ) ? sz_acc :
                 (state_reg == ST_WR_REQ) ? acc_reg : ACC_1B;
  assign wdata = (state_reg == ST_WR_REQ) ? data_reg : '0;

  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign err      = err_reg;
  assign err_addr = err_addr_reg;

endmodule

// File: tb/tb_bus_dma.sv
// tb_bus_dma -- directed self-checking bench for bus_dma.
// A byte-array memory model answers every request one cycle later.
module tb_bus_dma;
  import bus_dma_pkg::*;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [31:0]       src, dst;
  logic [15:0]       len;
  logic              busy, done, err, w_rb, req, resp, fault;
  logic [31:0]       err_addr, addr;
  logic [ACC_W-1:0]  acc;
  logic [BUS_W-1:0]  wdata, rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]       mem [0:1023];
  logic             pending;
  bit               no_resp;
  bit               fault_en;
  logic [31:0]      fault_at;
  int               log_cnt;
  logic             log_w   [0:31];
  logic [ACC_W-1:0] log_acc [0:31];
  logic [31:0]      log_adr [0:31];

  bus_dma #(.TIMEOUT(4), .LEN_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr), .addr(addr),
    .w_rb(w_rb), .acc(acc), .wdata(wdata), .req(req), .rdata(rdata),
    .resp(resp), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, act);
    end
  endtask

  function automatic int acc_bytes(input logic [ACC_W-1:0] a);
    if (a == ACC_1B) return 1;
    if (a == ACC_2B) return 2;
    if (a == ACC_4B) return 4;
    return 0;
  endfunction

  function automatic logic [7:0] pat(input int a);
    logic [9:0] v;
    v = 10'(a);
    return v[7:0] ^ {6'b0, v[9:8]} ^ 8'hA5;
  endfunction

  task automatic init_mem();
    for (int i = 0; i < 1024; i++) mem[i] = (i < 512) ? pat(i) : 8'hEE;
  endtask

  // Number of destination bytes that do not hold the source pattern.
  function automatic int copy_errors(input int s, input int d, input int l);
    int e = 0;
    for (int i = 0; i < l; i++) if (mem[(d + i) & 1023] !== pat(s + i)) e++;
    return e;
  endfunction

  // Responder: sees req at the negedge of the req cycle, answers in the next.
  initial begin
    resp = 1'b0; fault = 1'b0; rdata = '0; pending = 1'b0;
    forever begin
      @(negedge clk);
      resp = 1'b0;
      fault = 1'b0;
      if (!rstn) begin
        pending = 1'b0;
      end else if (pending) begin
        resp = 1'b1;
        pending = 1'b0;
      end else if (req) begin
        if (log_cnt < 32) begin
          log_w[log_cnt] = w_rb; log_acc[log_cnt] = acc; log_adr[log_cnt] = addr;
        end
        log_cnt++;
        if (fault_en && w_rb && addr == fault_at) begin
          fault = 1'b1;
        end else if (!no_resp) begin
          for (int b = 0; b < 4; b++) begin
            if (w_rb) begin
              if (b < acc_bytes(acc)) mem[int'((addr + 32'(b)) & 32'h3FF)] = wdata[b*8 +: 8];
            end else begin
              rdata[b*8 +: 8] = (b < acc_bytes(acc)) ? mem[int'((addr + 32'(b)) & 32'h3FF)] : 8'h00;
            end
          end
          pending = 1'b1;
        end
      end
    end
  end

  // Start a transfer and wait for done/err; lat counts cycles after the
  // start-sampling edge (200 means the wait budget expired).
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                          input bit poke, output int lat, output logic sd, output logic se);
    log_cnt = 0;
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = l;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!(done || err) && lat < 200) begin
      if (poke && lat == 3) begin
        start = 1'b1; src = 32'h3F0; dst = 32'h3F8; len = 16'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    sd = done;
    se = err;
  endtask

  int   lat;
  logic sd, se;

  initial begin
    rstn = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    no_resp = 1'b0; fault_en = 1'b0; fault_at = '0; log_cnt = 0;
    init_mem();
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_req", {31'b0, req}, 0);
    check("rst_done_err", {30'b0, done, err}, 0);
    check("rst_addr", addr, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_w_rb", {31'b0, w_rb}, 0);
    check("rst_acc", 32'(acc), 32'(ACC_1B));
    rstn = 1'b1;

    // Aligned copy: R4 W4 R4 W4, done 10 cycles after start.
    init_mem();
    run_xfer(32'h100, 32'h200, 16'd8, 1'b0, lat, sd, se);
    check("aln_latency", 32'(lat), 10);
    check("aln_done_err", {30'b0, sd, se}, 32'b10);
    check("aln_busy_at_done", {31'b0, busy}, 0);
    check("aln_req_count", 32'(log_cnt), 4);
    check("aln_b0", {log_w[0], 2'(acc_bytes(log_acc[0])), log_adr[0][11:0]}, {1'b0, 2'(0), 12'h100});
    check("aln_b1", {log_w[1], 3'(acc_bytes(log_acc[1])), log_adr[1][11:0]}, {1'b1, 3'd4, 12'h200});
    check("aln_b2", {log_w[2], 3'(acc_bytes(log_acc[2])), log_adr[2][11:0]}, {1'b0, 3'd4, 12'h104});
    check("aln_b3", {log_w[3], 3'(acc_bytes(log_acc[3])), log_adr[3][11:0]}, {1'b1, 3'd4, 12'h204});
    check("aln_data", 32'(copy_errors(32'h100, 32'h200, 8)), 0);
    check("aln_no_overrun", {24'b0, mem[32'h208]}, 32'hEE);

    // Odd copy 0x101 -> 0x203, len 5: sizes 1, 2, 2.
    init_mem();
    run_xfer(32'h101, 32'h203, 16'd5, 1'b0, lat, sd, se);
    check("odd_done_err", {30'b0, sd, se}, 32'b10);
    check("odd_req_count", 32'(log_cnt), 6);
    check("odd_sizes", {8'(acc_bytes(log_acc[0])), 8'(acc_bytes(log_acc[2])), 8'(acc_bytes(log_acc[4])), 8'(acc_bytes(log_acc[5]))},
          {8'd1, 8'd2, 8'd2, 8'd2});
    check("odd_last_wr_addr", log_adr[5], 32'h206);
    check("odd_data", 32'(copy_errors(32'h101, 32'h203, 5)), 0);
    check("odd_no_overrun", {24'b0, mem[32'h208]}, 32'hEE);

    // Mixed alignment 0x102 -> 0x206, len 7: sizes 2, 4, 1; a start pulse
    // while busy must be ignored.
    init_mem();
    run_xfer(32'h102, 32'h206, 16'd7, 1'b1, lat, sd, se);
    check("mix_done_err", {30'b0, sd, se}, 32'b10);
    check("mix_req_count", 32'(log_cnt), 6);
    check("mix_sizes", {8'(acc_bytes(log_acc[0])), 8'(acc_bytes(log_acc[2])), 8'(acc_bytes(log_acc[4])), 8'(acc_bytes(log_acc[5]))},
          {8'd2, 8'd4, 8'd1, 8'd1});
    check("mix_rd_addrs", {log_adr[2][15:0], log_adr[4][15:0]}, {16'h104, 16'h108});
    check("mix_data", 32'(copy_errors(32'h102, 32'h206, 7)), 0);
    check("mix_no_overrun", {24'b0, mem[32'h20D]}, 32'hEE);

    // Fault on the write to 0x204.
    init_mem();
    fault_en = 1'b1; fault_at = 32'h204;
    run_xfer(32'h100, 32'h200, 16'd8, 1'b0, lat, sd, se);
    fault_en = 1'b0;
    check("flt_done_err", {30'b0, sd, se}, 32'b01);
    check("flt_err_addr", err_addr, 32'h204);
    repeat (10) @(negedge clk);
    check("flt_req_count", 32'(log_cnt), 4);
    check("flt_err_addr_held", err_addr, 32'h204);
    check("flt_not_written", {24'b0, mem[32'h204]}, 32'hEE);
    check("flt_first_word", 32'(copy_errors(32'h100, 32'h200, 4)), 0);

    // Timeout: no response, err 4 cycles after the read req (req at cycle 1).
    no_resp = 1'b1;
    run_xfer(32'h300, 32'h380, 16'd4, 1'b0, lat, sd, se);
    no_resp = 1'b0;
    check("tmo_latency", 32'(lat), 5);
    check("tmo_done_err", {30'b0, sd, se}, 32'b01);
    check("tmo_err_addr", err_addr, 32'h300);
    check("tmo_req_count", 32'(log_cnt), 1);

    // Zero length: done two cycles after start, no bus traffic.
    run_xfer(32'h100, 32'h200, 16'd0, 1'b0, lat, sd, se);
    check("len0_latency", 32'(lat), 2);
    check("len0_done_err", {30'b0, sd, se}, 32'b10);
    check("len0_req_count", 32'(log_cnt), 0);
    check("len0_err_addr_cleared", err_addr, 0);

    // Reset during RD_WAIT, then a clean transfer.
    init_mem();
    log_cnt = 0;
    @(negedge clk);
    start = 1'b1; src = 32'h100; dst = 32'h200; len = 16'd8;
    @(negedge clk);
    start = 1'b0;
    check("rsw_req_before", {31'b0, req}, 1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rsw_busy", {31'b0, busy}, 0);
    check("rsw_req", {31'b0, req}, 0);
    @(negedge clk);
    check("rsw_done_err", {30'b0, done, err}, 0);
    rstn = 1'b1;
    run_xfer(32'h100, 32'h200, 16'd8, 1'b0, lat, sd, se);
    check("rsw_latency", 32'(lat), 10);
    check("rsw_done_err_after", {30'b0, sd, se}, 32'b10);
    check("rsw_data", 32'(copy_errors(32'h100, 32'h200, 8)), 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
